// File: rtl/fetch_req_ctrl_pkg.sv
// Shared types and constants for the fetch request controller.
// Line geometry, address alignment and FSM state encoding.
package fetch_req_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int BUS_LEN    = 2;
    localparam int BUS_WID    = BUS_LEN * XLEN;
    localparam int LINE_BYTES = BUS_WID / 8;
    localparam int BUS_OFF    = $clog2(LINE_BYTES);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(LINE_BYTES - 1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_credit_cnt.sv
// In-flight read and stale-response discard counters.
// A flush reloads the discard count from the post-cycle in-flight count.
module fetch_credit_cnt #(
    parameter int MAX_OUT = 2,
    parameter int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic          i_flush,
    output logic [CW-1:0] o_inflight,
    output logic          o_drop
);

    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_inflight_nxt;
    logic [CW-1:0] w_discard_nxt;
    logic          w_drop;

    // Next-state computation for both counters
    always_comb begin
        w_inflight_nxt = r_inflight;
        w_discard_nxt  = r_discard;
        w_drop         = i_dec & (r_discard != {CW{1'b0}});
        case ({i_inc, i_dec})
            2'b10:   w_inflight_nxt = r_inflight + CW'(1);
            2'b01:   w_inflight_nxt = r_inflight - CW'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
        if (i_flush) begin
            w_discard_nxt = w_inflight_nxt;
        end else if (w_drop) begin
            w_discard_nxt = r_discard - CW'(1);
        end else begin
            w_discard_nxt = r_discard;
        end
    end

    // Counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= {CW{1'b0}};
            r_discard  <= {CW{1'b0}};
        end else begin
            r_inflight <= w_inflight_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    assign o_inflight = r_inflight;
    assign o_drop     = w_drop;

endmodule

// File: rtl/fetch_req_ctrl.sv
// Fetch request controller: boot redirect, line-aligned read issue with
// in-flight credit limit, and stale-response filtering after redirects.
module fetch_req_ctrl
    import fetch_req_ctrl_pkg::*;
#(
    parameter int              MAX_OUT = 2,
    parameter logic [XLEN-1:0] RST_PC  = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_core_jump_vld,
    input  logic [XLEN-1:0]    i_core_jump_pc,
    input  logic               i_buffer_free,
    output logic               o_imem_req,
    output logic [XLEN-1:0]    o_imem_addr,
    input  logic               i_imem_ack,
    input  logic               i_imem_resp_vld,
    input  logic [BUS_WID-1:0] i_imem_resp_data,
    output logic               o_jump_vld,
    output logic [XLEN-1:0]    o_jump_pc,
    output logic               o_line_vld,
    output logic [BUS_WID-1:0] o_line_data
);

    localparam int CW = $clog2(MAX_OUT + 1);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_fetch_addr;
    logic            w_jump_vld;
    logic [XLEN-1:0] w_jump_pc;
    logic            w_req;
    logic            w_accept;
    logic [CW-1:0]   w_inflight;
    logic            w_drop;

    // Boot sequencing and redirect source selection
    always_comb begin
        w_state_nxt = r_state;
        w_jump_vld  = 1'b0;
        w_jump_pc   = {XLEN{1'b0}};
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_BOOT;
            end
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
                w_jump_vld  = 1'b1;
                w_jump_pc   = RST_PC;
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
                w_jump_vld  = i_core_jump_vld;
                w_jump_pc   = i_core_jump_pc;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_req    = (r_state == ST_RUN) & ~w_jump_vld & i_buffer_free
                    & (w_inflight < CW'(MAX_OUT));
    assign w_accept = w_req & i_imem_ack;

    // State and fetch-address registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_fetch_addr <= align(RST_PC);
        end else begin
            r_state <= w_state_nxt;
            if (w_jump_vld) begin
                r_fetch_addr <= align(w_jump_pc);
            end else if (w_accept) begin
                r_fetch_addr <= r_fetch_addr + XLEN'(LINE_BYTES);
            end else begin
                r_fetch_addr <= r_fetch_addr;
            end
        end
    end

    fetch_credit_cnt #(
        .MAX_OUT (MAX_OUT),
        .CW      (CW)
    ) u_credit (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (w_accept),
        .i_dec      (i_imem_resp_vld),
        .i_flush    (w_jump_vld),
        .o_inflight (w_inflight),
        .o_drop     (w_drop)
    );

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_fetch_addr;
    assign o_jump_vld  = w_jump_vld;
    assign o_jump_pc   = w_jump_pc;
    // A response landing in a redirect cycle is stale even when nothing is pending discard
    assign o_line_vld  = i_imem_resp_vld & ~w_drop & ~w_jump_vld;
    assign o_line_data = i_imem_resp_data;

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Directed bench for fetch_req_ctrl with a 1-cycle in-order memory model and
// scoreboards for expected request addresses and line deliveries.
module tb_fetch_req_ctrl;
    import fetch_req_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               core_jump_vld;
    logic [XLEN-1:0]    core_jump_pc;
    logic               buffer_free;
    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_ack;
    logic               imem_resp_vld;
    logic [BUS_WID-1:0] imem_resp_data;
    logic               jump_vld;
    logic [XLEN-1:0]    jump_pc;
    logic               line_vld;
    logic [BUS_WID-1:0] line_data;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0]    exp_req_q[$];
    logic [XLEN-1:0]    mem_q[$];
    logic               exp_lv_q[$];
    logic [BUS_WID-1:0] exp_data_q[$];

    logic               exp_jv;
    logic [XLEN-1:0]    exp_jpc;
    logic               exp_noreq;
    logic [XLEN-1:0]    exp_hold;

    fetch_req_ctrl #(.MAX_OUT(2), .RST_PC(32'h0000_0000)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_core_jump_vld  (core_jump_vld),
        .i_core_jump_pc   (core_jump_pc),
        .i_buffer_free    (buffer_free),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ack       (imem_ack),
        .i_imem_resp_vld  (imem_resp_vld),
        .i_imem_resp_data (imem_resp_data),
        .o_jump_vld       (jump_vld),
        .o_jump_pc        (jump_pc),
        .o_line_vld       (line_vld),
        .o_line_data      (line_data)
    );

    always #5 clk = ~clk;

    function automatic logic [BUS_WID-1:0] mk_data(input logic [XLEN-1:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: optionally return the oldest read, then check outputs at negedge.
    task automatic tick(input bit rsp, input bit lv);
        logic [XLEN-1:0]    a;
        logic               elv;
        logic [BUS_WID-1:0] ed;
        if (rsp) begin
            checks++;
            assert (mem_q.size() != 0) else begin
                errors++;
                $error("FAIL resp_avail: observed %0d expected >0", mem_q.size());
            end
            if (mem_q.size() != 0) begin
                a = mem_q.pop_front();
                imem_resp_vld  = 1'b1;
                imem_resp_data = mk_data(a);
                exp_lv_q.push_back(lv);
                exp_data_q.push_back(mk_data(a));
            end
        end
        @(negedge clk);
        if (imem_resp_vld) begin
            elv = exp_lv_q.pop_front();
            ed  = exp_data_q.pop_front();
            chk("line_vld", 64'(line_vld), 64'(elv));
            if (elv) chk("line_data", line_data, ed);
        end else begin
            chk("line_idle", 64'(line_vld), 64'(1'b0));
        end
        chk("jump_vld", 64'(jump_vld), 64'(exp_jv));
        if (exp_jv) chk("jump_pc", 64'(jump_pc), 64'(exp_jpc));
        if (exp_noreq) begin
            chk("req_low", 64'(imem_req), 64'(1'b0));
            chk("addr_held", 64'(imem_addr), 64'(exp_hold));
        end
        if (imem_req && imem_ack) begin
            mem_q.push_back(imem_addr);
            checks++;
            assert (exp_req_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_req: observed %0h expected none", imem_addr);
            end
            if (exp_req_q.size() != 0) chk("req_addr", 64'(imem_addr), 64'(exp_req_q.pop_front()));
        end
        @(posedge clk);
        #1;
        imem_resp_vld  = 1'b0;
        imem_resp_data = '0;
    endtask

    initial begin
        rst = 1'b1; core_jump_vld = 1'b0; core_jump_pc = '0; buffer_free = 1'b0;
        imem_ack = 1'b0; imem_resp_vld = 1'b0; imem_resp_data = '0;
        exp_jv = 1'b0; exp_jpc = '0; exp_noreq = 1'b0; exp_hold = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 64'(imem_req), 64'(1'b0));
        chk("rst_addr", 64'(imem_addr), 64'(32'h0));
        chk("rst_jump", 64'(jump_vld), 64'(1'b0));
        chk("rst_line", 64'(line_vld), 64'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0; imem_ack = 1'b1; buffer_free = 1'b1;

        // IDLE then BOOT: boot redirect to vector, no request
        exp_noreq = 1'b1; exp_hold = 32'h0;
        tick(0, 0);
        exp_jv = 1'b1; exp_jpc = 32'h0;
        tick(0, 0);
        exp_jv = 1'b0; exp_noreq = 1'b0;

        // Streaming at 1-cycle latency: 0x0, 0x8, 0x10
        exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h8); exp_req_q.push_back(32'h10);
        tick(0, 0); tick(1, 1); tick(1, 1);
        buffer_free = 1'b0;
        tick(1, 1);

        // Backpressure holds address
        exp_noreq = 1'b1; exp_hold = 32'h18;
        repeat (5) tick(0, 0);
        exp_noreq = 1'b0; buffer_free = 1'b1;

        // Throttle at MAX_OUT with responses withheld
        exp_req_q.push_back(32'h18); exp_req_q.push_back(32'h20);
        tick(0, 0); tick(0, 0);
        exp_noreq = 1'b1; exp_hold = 32'h28;
        tick(0, 0); tick(0, 0);

        // Redirect with 2 in flight: both responses discarded
        core_jump_vld = 1'b1; core_jump_pc = 32'h104; exp_jv = 1'b1; exp_jpc = 32'h104;
        tick(0, 0);
        core_jump_vld = 1'b0; exp_jv = 1'b0; buffer_free = 1'b0; exp_hold = 32'h100;
        tick(1, 0); tick(1, 0);
        exp_noreq = 1'b0; buffer_free = 1'b1;
        exp_req_q.push_back(32'h100);
        tick(0, 0);
        buffer_free = 1'b0; exp_noreq = 1'b1; exp_hold = 32'h108;
        tick(1, 1);

        // Redirect coincident with the only response
        exp_noreq = 1'b0; buffer_free = 1'b1;
        exp_req_q.push_back(32'h108);
        tick(0, 0);
        core_jump_vld = 1'b1; core_jump_pc = 32'h200; exp_jv = 1'b1; exp_jpc = 32'h200;
        exp_noreq = 1'b1; exp_hold = 32'h110;
        tick(1, 0);
        core_jump_vld = 1'b0; exp_jv = 1'b0; exp_noreq = 1'b0;
        exp_req_q.push_back(32'h200);
        tick(0, 0);
        buffer_free = 1'b0; exp_noreq = 1'b1; exp_hold = 32'h208;
        tick(1, 1);

        // Address wrap at top of memory
        buffer_free = 1'b1;
        core_jump_vld = 1'b1; core_jump_pc = 32'hFFFF_FFF8; exp_jv = 1'b1; exp_jpc = 32'hFFFF_FFF8;
        tick(0, 0);
        core_jump_vld = 1'b0; exp_jv = 1'b0; exp_noreq = 1'b0;
        exp_req_q.push_back(32'hFFFF_FFF8); exp_req_q.push_back(32'h0);
        tick(0, 0); tick(1, 1);
        buffer_free = 1'b0; exp_noreq = 1'b1; exp_hold = 32'h8;
        tick(1, 1);

        chk("mem_drained", 64'(mem_q.size()), 64'(0));
        chk("reqs_consumed", 64'(exp_req_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_req_ctrl.md
# fetch_req_ctrl

Front-end fetch request controller sitting directly upstream of the instruction line buffer. It generates line-aligned instruction-memory read requests, tracks in-flight reads, and discards stale responses after a redirect. It delivers valid lines plus the jump/redirect indication that the line buffer consumes, throttled by the buffer's `buffer_free` credit. Boot redirect to the reset vector is issued from here.

## Interface
- `XLEN`, 32, data/address width
- `BUS_LEN`, 2, instruction words per memory line; `BUS_WID = BUS_LEN*XLEN`
- `MAX_OUT`, 2, maximum in-flight memory reads (1..7)
- `RST_PC`, 32'h0000_0000, boot vector
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset; one clock, all state in this block
- `core_jump_vld`  in  1  redirect request from execute/schedule
- `core_jump_pc`  in  XLEN  redirect target; bits [1:0] are always 0
- `buffer_free`  in  1  line buffer can accept one more line
- `imem_req`  out  1  read request valid
- `imem_addr`  out  XLEN  line-aligned read address (low log2(BUS_WID/8) bits zero)
- `imem_ack`  in  1  request accepted this cycle when `imem_req & imem_ack`
- `imem_resp_vld`  in  1  read data valid; responses return in request order, ≥1 cycle after accept
- `imem_resp_data`  in  BUS_WID  read line
- `jump_vld`  out  1  redirect pulse to line buffer
- `jump_pc`  out  XLEN  redirect target (unaligned word address)
- `line_vld`  out  1  line valid to line buffer
- `line_data`  out  BUS_WID  line (= `imem_resp_data`)

## Operation
- States: IDLE (reset value) → BOOT (unconditional, first edge after reset release) → RUN (next edge). RUN is terminal until reset.
- BOOT: `jump_vld=1`, `jump_pc=RST_PC`, `imem_req=0`; `fetch_addr <= align(RST_PC)`.
- RUN: `jump_vld = core_jump_vld`, `jump_pc = core_jump_pc`.
- Redirect (any `jump_vld` cycle): `imem_req=0`; `line_vld=0`; `fetch_addr <= align(jump_pc)`; `discard <= inflight_next`, where `inflight_next` counts all reads still outstanding after this cycle's response.
- Issue: `imem_req = RUN & !jump_vld & buffer_free & (inflight < MAX_OUT)`; `imem_addr = fetch_addr`. On accept, `fetch_addr += BUS_WID/8` modulo 2^XLEN (wraps to 0); `inflight += 1`.
- Response: `inflight -= 1`. If `discard != 0`, drop it and decrement `discard`. Otherwise `line_vld = !jump_vld`, meaning a response in a redirect cycle is dropped.
- Accept and response in the same cycle leave `inflight` unchanged.
- Invariant: `discard ≤ inflight ≤ MAX_OUT`; counters are clog2(MAX_OUT+1) bits.
- `imem_req` may drop without ack (redirect, `buffer_free` low). The memory side does not require request stability.
- A `core_jump_vld` in IDLE/BOOT is ignored.

## Timing
- Reset values: state IDLE, `fetch_addr=align(RST_PC)`, `inflight=0`, `discard=0`. All outputs are 0 (`imem_addr` = align(RST_PC)).
- `jump_vld` first asserts in the cycle after the first post-reset edge. The first `imem_req` follows 1 cycle later.
- `line_vld`/`line_data` are combinational from `imem_resp_*` (0-cycle pass-through). `jump_vld` in RUN is combinational from `core_jump_vld`.
- Back-to-back redirects: each one recomputes `discard` from the current in-flight count. The last redirect's target wins.
- Reset mid-operation: counters clear, so responses to pre-reset requests would be misaccounted. The memory side is reset with the same `rst`.

## Structure
- Shared package/define file: `XLEN`, `BUS_LEN`, `BUS_WID`, `BUS_OFF`, line byte size, `align()` mask, state encoding.
- One natural sub-module, `fetch_credit_cnt`: `inflight`/`discard` counters with inc/dec/flush inputs. Everything else stays inline.

## Test plan
- Boot: release `rst`, `imem_ack=1`, 1-cycle latency, `buffer_free=1` → `jump_vld` pulse with `jump_pc=0`. Requests go to 0x0, 0x8, 0x10. `line_vld` follows each accept by 1 cycle.
- Throttle: MAX_OUT=2, hold `imem_resp_vld=0` → exactly 2 accepts, then `imem_req=0` until a response returns.
- Redirect with 2 in flight: `core_jump_pc=0x104` → `imem_req` low that cycle. The next 2 responses give `line_vld=0`. The next request address is 0x100 and its response gives `line_vld=1`.
- Redirect coincident with response: 1 in flight, response and `core_jump_vld` in the same cycle → `line_vld=0`, `discard=0`. The next request goes to the new target.
- Backpressure: `buffer_free=0` for 5 cycles → no requests, address held. Raising it resumes at the held address.
- Wrap: redirect to 0xFFFF_FFF8 → requests 0xFFFF_FFF8, then 0x0000_0000.
